// File: rtl/aes_pkg.sv
// Shared AES definitions: block type, FSM states, round count, S-boxes and
// the GF(2^8) column mixers used by the combinational round.
package aes_pkg;

  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic int nr_from_key_bits(input int key_bits);
    case (key_bits)
      192:     return 12;
      256:     return 14;
      default: return 10;
    endcase
  endfunction

  // Entry i lives at bits [(255-i)*8 +: 8], i.e. byte 0 is the leftmost.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX_TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column bytes are row 0 in [31:24] down to row 3 in [7:0].
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] x [4];
    for (int i = 0; i < 4; i++) begin
      a[i] = col[31-8*i -: 8];
      x[i] = xtime(a[i]);
    end
    return {x[0] ^ x[1] ^ a[1] ^ a[2] ^ a[3],
            a[0] ^ x[1] ^ x[2] ^ a[2] ^ a[3],
            a[0] ^ a[1] ^ x[2] ^ x[3] ^ a[3],
            x[0] ^ a[0] ^ a[1] ^ a[2] ^ x[3]};
  endfunction

  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m2, m4, m8;
    logic [7:0] m9 [4];
    logic [7:0] m11 [4];
    logic [7:0] m13 [4];
    logic [7:0] m14 [4];
    for (int i = 0; i < 4; i++) begin
      a[i]   = col[31-8*i -: 8];
      m2     = xtime(a[i]);
      m4     = xtime(m2);
      m8     = xtime(m4);
      m9[i]  = m8 ^ a[i];
      m11[i] = m8 ^ m2 ^ a[i];
      m13[i] = m8 ^ m4 ^ a[i];
      m14[i] = m8 ^ m4 ^ m2;
    end
    return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
            m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
            m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
            m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
  endfunction

endpackage

// File: rtl/aes_round.sv
// Combinational AES round, forward or inverse; last selects the round
// without (Inv)MixColumns. Block byte k sits at row k%4, column k/4.
module aes_round
  import aes_pkg::*;
(
  input  logic   dir,
  input  logic   last,
  input  block_t stm,
  input  block_t rk,
  output block_t next_stm
);

  logic [7:0] in_b  [16];
  logic [7:0] sb_b  [16];
  logic [7:0] sr_b  [16];
  logic [7:0] isr_b [16];
  logic [7:0] isb_b [16];

  block_t sr_blk;
  block_t mc_blk;
  block_t isb_blk;
  block_t ark_blk;
  block_t imc_blk;
  block_t enc_blk;
  block_t dec_blk;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_byte
      localparam int ROW = gi % 4;
      localparam int COL = gi / 4;
      assign in_b[gi]  = stm[127-8*gi -: 8];
      assign sb_b[gi]  = sbox(in_b[gi]);
      assign sr_b[gi]  = sb_b[ROW + 4*((COL + ROW) % 4)];
      assign isr_b[gi] = in_b[ROW + 4*((COL + 4 - ROW) % 4)];
      assign isb_b[gi] = inv_sbox(isr_b[gi]);
      assign sr_blk[127-8*gi -: 8]  = sr_b[gi];
      assign isb_blk[127-8*gi -: 8] = isb_b[gi];
    end

    for (gi = 0; gi < 4; gi++) begin : g_col
      assign mc_blk[127-32*gi -: 32]  = mix_column(sr_blk[127-32*gi -: 32]);
      assign imc_blk[127-32*gi -: 32] = inv_mix_column(ark_blk[127-32*gi -: 32]);
    end
  endgenerate

  // Inverse rounds add the key before InvMixColumns, so the external
  // schedule can serve the same round keys in both directions.
  assign ark_blk  = isb_blk ^ rk;
  assign dec_blk  = last ? ark_blk : imc_blk;
  assign enc_blk  = (last ? sr_blk : mc_blk) ^ rk;
  assign next_stm = dir ? dec_blk : enc_blk;

endmodule

// File: rtl/aes_round_engine.sv
// Iterative AES engine: one round per cycle with an external key schedule
// addressed through rk_idx, and a valid/ready handshake on both sides.
module aes_round_engine
  import aes_pkg::*;
#(
  parameter int KEY_BITS   = 128,
  parameter bit DECRYPT_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         dir,
  input  logic [127:0] in_block,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         busy
);

  localparam int         NR   = nr_from_key_bits(KEY_BITS);
  localparam logic [3:0] NR_W = 4'(NR);

  state_e     state_q;
  block_t     stm_q;
  block_t     stm_d;
  logic [3:0] r_q;
  logic       dir_q;
  logic       in_ready_q;
  logic       out_valid_q;
  logic       busy_q;

  logic dir_in;
  logic last_round;
  logic settle;

  assign dir_in     = dir & DECRYPT_EN;
  assign last_round = (r_q == NR_W);
  // After round Nr one settle cycle in ROUND (r = Nr+1) holds stm, so
  // out_valid rises Nr+1 edges after the accept edge.
  assign settle     = (r_q == NR_W + 4'd1);

  always_comb begin
    rk_idx = 4'd0;
    case (state_q)
      ST_IDLE:  rk_idx = dir_in ? NR_W : 4'd0;
      ST_ROUND: if (!settle) rk_idx = dir_q ? (NR_W - r_q) : r_q;
      default:  rk_idx = 4'd0;
    endcase
  end

  aes_round u_round (
    .dir      (dir_q),
    .last     (last_round),
    .stm      (stm_q),
    .rk       (rk),
    .next_stm (stm_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      stm_q       <= '0;
      r_q         <= 4'd0;
      dir_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            dir_q      <= dir_in;
            stm_q      <= in_block ^ rk;
            r_q        <= 4'd1;
            state_q    <= ST_ROUND;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ST_ROUND: begin
          if (settle) begin
            state_q     <= ST_DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            stm_q <= stm_d;
            r_q   <= r_q + 4'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_block = stm_q;

endmodule

// File: tb/tb_aes_round_engine.sv
// Bench for aes_round_engine: AES-128/192/256 and an encrypt-only build,
// checked against FIPS-197 vectors and a byte-level AES model.
module tb_aes_round_engine;

  localparam int NI = 4;

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C2_CT  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] C1_KEY = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] C2_KEY = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid_a  [NI];
  logic         in_ready_a  [NI];
  logic         dir_a       [NI];
  logic [127:0] in_block_a  [NI];
  logic [3:0]   rk_idx_a    [NI];
  logic [127:0] rk_a        [NI];
  logic         out_valid_a [NI];
  logic         out_ready_a [NI];
  logic [127:0] out_block_a [NI];
  logic         busy_a      [NI];

  logic [127:0] rkeys [NI][15];
  logic [7:0]   sbox_tab [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_dut
      aes_round_engine #(
        .KEY_BITS   (gi == 1 ? 192 : (gi == 2 ? 256 : 128)),
        .DECRYPT_EN (gi == 3 ? 1'b0 : 1'b1)
      ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid_a[gi]),
        .in_ready  (in_ready_a[gi]),
        .dir       (dir_a[gi]),
        .in_block  (in_block_a[gi]),
        .rk_idx    (rk_idx_a[gi]),
        .rk        (rk_a[gi]),
        .out_valid (out_valid_a[gi]),
        .out_ready (out_ready_a[gi]),
        .out_block (out_block_a[gi]),
        .busy      (busy_a[gi])
      );
      assign rk_a[gi] = (rk_idx_a[gi] < 4'd15) ? rkeys[gi][rk_idx_a[gi]] : '0;
    end
  endgenerate

  function automatic int nr_of(input int k);
    return (k == 1) ? 12 : ((k == 2) ? 14 : 10);
  endfunction

  function automatic int kb_of(input int k);
    return (k == 1) ? 192 : ((k == 2) ? 256 : 128);
  endfunction

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_idx(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_blk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Generic GF(2^8) product, modulus x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    logic [7:0] inv, s, rr;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv; rr = inv;
      for (int n = 0; n < 4; n++) begin
        rr = {rr[6:0], rr[7]};
        s ^= rr;
      end
      sbox_tab[x] = s ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  task automatic expand_key(input int k, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon;
    int nk, nr;
    nk = kb_of(k) / 32;
    nr = nr_of(k);
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rkeys[k][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] model_encrypt(input int k, input logic [127:0] pt);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] res;
    int nr;
    nr = nr_of(k);
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rkeys[k][0][127-8*i -: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r+4*c] = sbox_tab[s[r + 4*((c+r) % 4)]];
      if (rnd < nr) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            s[r+4*c] = gmul(8'h02, t[r+4*c]) ^ gmul(8'h03, t[(r+1)%4 + 4*c])
                     ^ t[(r+2)%4 + 4*c] ^ t[(r+3)%4 + 4*c];
      end else begin
        s = t;
      end
      for (int i = 0; i < 16; i++) s[i] ^= rkeys[k][rnd][127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One complete transaction; junk on in_valid/out_ready during ROUND must be ignored.
  task automatic run_block(input int k, input bit d, input logic [127:0] blk,
                           input logic [127:0] exp_out, input int hold);
    int nr;
    bit d_eff;
    nr = nr_of(k);
    d_eff = d && (k != 3);
    @(negedge clk);
    dir_a[k] = d;
    in_block_a[k] = blk;
    #1;
    chk_bit("in_ready_idle", in_ready_a[k], 1'b1);
    chk_idx("rk_idx_idle", rk_idx_a[k], d_eff ? 4'(nr) : 4'd0);
    in_valid_a[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_block_a[k] = rand128();
    dir_a[k] = ~d;
    for (int n = 0; n <= nr; n++) begin
      chk_bit("busy_round", busy_a[k], 1'b1);
      chk_bit("out_valid_early", out_valid_a[k], 1'b0);
      chk_bit("in_ready_busy", in_ready_a[k], 1'b0);
      if (n < nr) chk_idx("rk_idx_round", rk_idx_a[k], d_eff ? 4'(nr - n - 1) : 4'(n + 1));
      out_ready_a[k] = (n < nr);
      @(posedge clk);
      @(negedge clk);
    end
    chk_bit("out_valid_done", out_valid_a[k], 1'b1);
    chk_bit("busy_done", busy_a[k], 1'b0);
    chk_blk("out_block", out_block_a[k], exp_out);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      chk_blk("hold_out_block", out_block_a[k], exp_out);
      chk_bit("hold_out_valid", out_valid_a[k], 1'b1);
      chk_bit("hold_in_ready", in_ready_a[k], 1'b0);
    end
    in_valid_a[k] = 1'b0;
    out_ready_a[k] = 1'b1;
    #1;
    chk_bit("in_ready_same_cycle", in_ready_a[k], 1'b0);
    @(posedge clk);
    @(negedge clk);
    out_ready_a[k] = 1'b0;
    chk_bit("in_ready_after_pop", in_ready_a[k], 1'b1);
    chk_bit("out_valid_after_pop", out_valid_a[k], 1'b0);
    $display("block inst=%0d dir=%0d in=%h out=%h expected=%h hold=%0d",
             k, d, blk, out_block_a[k], exp_out, hold);
  endtask

  initial begin
    logic [127:0] pt, ct;
    int k;
    build_sbox();
    reset = 1'b1;
    for (int i = 0; i < NI; i++) begin
      in_valid_a[i] = 1'b0; dir_a[i] = 1'b0; in_block_a[i] = '0; out_ready_a[i] = 1'b0;
    end
    expand_key(0, C1_KEY);
    expand_key(1, C2_KEY);
    expand_key(2, C3_KEY);
    expand_key(3, C1_KEY);
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk_bit("rst_in_ready", in_ready_a[i], 1'b1);
      chk_bit("rst_out_valid", out_valid_a[i], 1'b0);
      chk_bit("rst_busy", busy_a[i], 1'b0);
      chk_blk("rst_out_block", out_block_a[i], '0);
    end
    reset = 1'b0;

    run_block(0, 1'b0, PT, C1_CT, 0);
    run_block(1, 1'b0, PT, C2_CT, 0);
    run_block(2, 1'b0, PT, C3_CT, 0);
    run_block(0, 1'b1, C1_CT, PT, 0);
    run_block(0, 1'b0, PT, C1_CT, 5);
    run_block(3, 1'b1, PT, C1_CT, 1);

    // Abort mid-computation: the partial state must never be presented.
    @(negedge clk);
    dir_a[0] = 1'b0;
    in_block_a[0] = PT;
    in_valid_a[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_a[0] = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_bit("abort_in_ready", in_ready_a[0], 1'b1);
    chk_bit("abort_busy", busy_a[0], 1'b0);
    chk_bit("abort_out_valid", out_valid_a[0], 1'b0);
    chk_blk("abort_out_block", out_block_a[0], '0);
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      chk_bit("abort_no_valid", out_valid_a[0], 1'b0);
    end
    $display("abort inst=0 reset during round, out_valid held low");
    run_block(0, 1'b0, PT, C1_CT, 0);

    for (int t = 0; t < 8; t++) begin
      k = t % NI;
      expand_key(k, {rand128(), rand128()});
      pt = rand128();
      ct = model_encrypt(k, pt);
      run_block(k, (k == 3) ? 1'b1 : 1'b0, pt, ct, $urandom_range(0, 2));
      if (k != 3) run_block(k, 1'b1, ct, pt, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
